// File: rtl/prime_game_pkg.sv
// prime_game_pkg: shared FSM encoding and default sizing for the prime guessing round
package prime_game_pkg;
    localparam int NUM_W_DEF = 8;
    localparam int SCORE_W_DEF = 8;
    localparam int WINDOW_CYCLES_DEF = 50000000;
    typedef enum logic [1:0] {IDLE, REQ, CHECK, PRESENT} state_t;
endpackage

// File: rtl/round_window_timer.sv
// round_window_timer: answer-window down-counter, loads CYCLES-1 and stops at zero
module round_window_timer #(
    parameter int CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic zero
);
    localparam int CW = $clog2(CYCLES);
    logic [CW-1:0] cnt;
    assign zero = cnt == '0;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= CW'(CYCLES - 1);
        else if (count && !zero) cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/prime_round_sequencer.sv
// prime_round_sequencer: fetches a random number, checks primality, presents it and scores the guess
module prime_round_sequencer
    import prime_game_pkg::*;
#(
    parameter int NUM_W = NUM_W_DEF,
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               score_clr,
    output logic               rng_req,
    input  logic               rng_valid,
    input  logic [NUM_W-1:0]   rng_value,
    output logic               prime_start,
    input  logic               prime_done,
    input  logic               prime_is_prime,
    input  logic               btn_prime,
    input  logic               btn_notprime,
    output logic [NUM_W-1:0]   num_out,
    output logic               num_valid,
    output logic               result_ok,
    output logic               result_miss,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         round_cnt
);
    state_t state, state_n;
    logic is_prime_q, win_zero, win_load, got_num, guess, in_play, hit, round_end;

    assign got_num = state == REQ && enable && rng_valid;
    assign win_load = state == CHECK && enable && prime_done;
    assign in_play = state == PRESENT && enable;
    assign guess = btn_prime ^ btn_notprime;
    assign hit = in_play && guess && (btn_prime == is_prime_q);
    // a guess landing on the final window cycle still counts as a guess, not a timeout
    assign round_end = in_play && (guess || win_zero);

    round_window_timer #(.CYCLES(WINDOW_CYCLES)) u_timer (
        .clk(clk),
        .rst(rst),
        .load(win_load),
        .count(state == PRESENT),
        .zero(win_zero)
    );

    always_comb begin
        state_n = state;
        rng_req = state == REQ && enable;
        num_valid = state == PRESENT;
        if (!enable) state_n = IDLE;
        else begin
            case (state)
                IDLE:    state_n = REQ;
                REQ:     state_n = rng_valid ? CHECK : REQ;
                CHECK:   state_n = prime_done ? PRESENT : CHECK;
                PRESENT: state_n = round_end ? REQ : PRESENT;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prime_start <= 1'b0;
            result_ok <= 1'b0;
            result_miss <= 1'b0;
            num_out <= '0;
            is_prime_q <= 1'b0;
            score <= '0;
            round_cnt <= '0;
        end else begin
            state <= state_n;
            prime_start <= got_num;
            result_ok <= hit;
            result_miss <= round_end && !hit;
            if (got_num) num_out <= rng_value;
            if (win_load) is_prime_q <= prime_is_prime;
            score <= score_clr ? '0 : (hit && score != '1) ? score + 1'b1 : score;
            round_cnt <= score_clr ? '0 : round_end ? round_cnt + 1'b1 : round_cnt;
        end
    end
endmodule

// File: tb/tb_prime_round_sequencer.sv
// tb_prime_round_sequencer: directed scenario tests for the prime guessing round sequencer
module tb_prime_round_sequencer;
    logic clk, rst, enable, score_clr, rng_req, rng_valid, prime_start, prime_done;
    logic prime_is_prime, btn_prime, btn_notprime, num_valid, result_ok, result_miss;
    logic [7:0] rng_value, num_out, score, round_cnt;
    int checks = 0;
    int errors = 0;

    prime_round_sequencer #(.NUM_W(8), .SCORE_W(8), .WINDOW_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .score_clr(score_clr),
        .rng_req(rng_req), .rng_valid(rng_valid), .rng_value(rng_value),
        .prime_start(prime_start), .prime_done(prime_done), .prime_is_prime(prime_is_prime),
        .btn_prime(btn_prime), .btn_notprime(btn_notprime),
        .num_out(num_out), .num_valid(num_valid), .result_ok(result_ok),
        .result_miss(result_miss), .score(score), .round_cnt(round_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic get_number(input logic [7:0] v, input logic p);
        int n = 0;
        while (rng_req !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        checks++;
        if (rng_req !== 1'b1) begin
            errors++;
            $display("FAIL rng_req_wait got %b want 1", rng_req);
        end
        rng_valid = 1; rng_value = v;
        tick;
        rng_valid = 0;
        prime_done = 1; prime_is_prime = p;
        tick;
        prime_done = 0;
    endtask

    task automatic press(input logic bp, input logic bnp);
        btn_prime = bp; btn_notprime = bnp;
        tick;
        btn_prime = 0; btn_notprime = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        tick;
        tick;
        checks++; if (rng_req !== 0 || prime_start !== 0) begin errors++; $display("FAIL reset_req got %b%b want 00", rng_req, prime_start); end
        checks++; if (num_valid !== 0 || result_ok !== 0 || result_miss !== 0) begin errors++; $display("FAIL reset_flags got %b%b%b want 000", num_valid, result_ok, result_miss); end
        checks++; if (num_out !== 0 || score !== 0 || round_cnt !== 0) begin errors++; $display("FAIL reset_regs got %0d %0d %0d want 0 0 0", num_out, score, round_cnt); end
        rst = 0;
        tick;
        checks++; if (rng_req !== 0) begin errors++; $display("FAIL idle_no_enable got %b want 0", rng_req); end
    endtask

    task automatic test_basic;
        enable = 1;
        tick;
        checks++; if (rng_req !== 1) begin errors++; $display("FAIL req_cycle1 got %b want 1", rng_req); end
        tick;
        tick;
        checks++; if (rng_req !== 1) begin errors++; $display("FAIL req_cycle3 got %b want 1", rng_req); end
        rng_valid = 1; rng_value = 7;
        tick;
        rng_valid = 0;
        checks++; if (num_out !== 7) begin errors++; $display("FAIL num_out got %0d want 7", num_out); end
        checks++; if (prime_start !== 1 || rng_req !== 0) begin errors++; $display("FAIL check_entry got start=%b req=%b want 1 0", prime_start, rng_req); end
        tick;
        checks++; if (prime_start !== 0) begin errors++; $display("FAIL start_pulse got %b want 0", prime_start); end
        prime_done = 1; prime_is_prime = 1;
        tick;
        prime_done = 0;
        checks++; if (num_valid !== 1) begin errors++; $display("FAIL present_valid got %b want 1", num_valid); end
        press(1, 0);
        checks++; if (result_ok !== 1 || result_miss !== 0) begin errors++; $display("FAIL ok_pulse got %b%b want 10", result_ok, result_miss); end
        checks++; if (score !== 1 || round_cnt !== 1) begin errors++; $display("FAIL basic_score got %0d %0d want 1 1", score, round_cnt); end
        checks++; if (num_valid !== 0 || rng_req !== 1) begin errors++; $display("FAIL round_end got valid=%b req=%b want 0 1", num_valid, rng_req); end
        tick;
        checks++; if (result_ok !== 0) begin errors++; $display("FAIL ok_single got %b want 0", result_ok); end
    endtask

    task automatic test_wrong;
        get_number(9, 0);
        press(1, 0);
        checks++; if (result_miss !== 1 || result_ok !== 0) begin errors++; $display("FAIL miss_pulse got %b%b want 01", result_ok, result_miss); end
        checks++; if (score !== 1 || round_cnt !== 2) begin errors++; $display("FAIL wrong_score got %0d %0d want 1 2", score, round_cnt); end
        tick;
        checks++; if (result_miss !== 0) begin errors++; $display("FAIL miss_single got %b want 0", result_miss); end
    endtask

    task automatic test_timeout;
        int n = 0;
        int misses = 0;
        get_number(5, 1);
        while (num_valid === 1'b1 && n < 20) begin
            n++;
            tick;
            if (result_miss === 1'b1) misses++;
        end
        checks++; if (n != 8) begin errors++; $display("FAIL window_len got %0d want 8", n); end
        checks++; if (rng_req !== 1 || round_cnt !== 3 || score !== 1) begin errors++; $display("FAIL timeout_state got req=%b rc=%0d sc=%0d want 1 3 1", rng_req, round_cnt, score); end
        for (int i = 0; i < 2; i++) begin
            tick;
            if (result_miss === 1'b1) misses++;
        end
        checks++; if (misses != 1) begin errors++; $display("FAIL timeout_miss got %0d want 1", misses); end
        get_number(11, 1);
        for (int i = 0; i < 7; i++) tick;
        press(1, 0);
        checks++; if (result_ok !== 1 || result_miss !== 0) begin errors++; $display("FAIL last_cycle got %b%b want 10", result_ok, result_miss); end
        checks++; if (score !== 2 || round_cnt !== 4) begin errors++; $display("FAIL last_score got %0d %0d want 2 4", score, round_cnt); end
        tick;
        checks++; if (result_miss !== 0) begin errors++; $display("FAIL last_no_miss got %b want 0", result_miss); end
    endtask

    task automatic test_both_buttons;
        get_number(4, 0);
        press(1, 1);
        checks++; if (result_ok !== 0 || result_miss !== 0 || num_valid !== 1) begin errors++; $display("FAIL both_ignored got %b%b%b want 001", result_ok, result_miss, num_valid); end
        press(0, 1);
        checks++; if (result_ok !== 1 || score !== 3 || round_cnt !== 5) begin errors++; $display("FAIL notprime_ok got %b %0d %0d want 1 3 5", result_ok, score, round_cnt); end
        press(1, 0);
        checks++; if (result_ok !== 0 || result_miss !== 0 || score !== 3) begin errors++; $display("FAIL btn_outside got %b%b %0d want 00 3", result_ok, result_miss, score); end
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 252; i++) begin
            get_number(2, 1);
            press(1, 0);
        end
        checks++; if (score !== 255) begin errors++; $display("FAIL preload got %0d want 255", score); end
        get_number(2, 1);
        press(1, 0);
        checks++; if (score !== 255 || result_ok !== 1) begin errors++; $display("FAIL saturate got %0d ok=%b want 255 1", score, result_ok); end
        checks++; if (round_cnt !== 2) begin errors++; $display("FAIL round_wrap got %0d want 2", round_cnt); end
        get_number(3, 1);
        score_clr = 1;
        press(1, 0);
        score_clr = 0;
        checks++; if (score !== 0 || round_cnt !== 0 || result_ok !== 1) begin errors++; $display("FAIL clr_priority got %0d %0d ok=%b want 0 0 1", score, round_cnt, result_ok); end
        get_number(2, 1);
        press(1, 0);
        checks++; if (score !== 1 || round_cnt !== 1) begin errors++; $display("FAIL after_clr got %0d %0d want 1 1", score, round_cnt); end
    endtask

    task automatic test_abort;
        int bad = 0;
        rng_valid = 1; rng_value = 13;
        tick;
        rng_valid = 0;
        checks++; if (prime_start !== 1) begin errors++; $display("FAIL abort_check got %b want 1", prime_start); end
        enable = 0;
        tick;
        checks++; if (rng_req !== 0 || num_valid !== 0) begin errors++; $display("FAIL abort_idle got %b%b want 00", rng_req, num_valid); end
        prime_done = 1; prime_is_prime = 1;
        tick;
        prime_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (result_ok | result_miss | num_valid | rng_req | prime_start) bad++;
            tick;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL abort_quiet got %0d want 0", bad); end
        checks++; if (score !== 1 || round_cnt !== 1 || num_out !== 13) begin errors++; $display("FAIL abort_retain got %0d %0d %0d want 1 1 13", score, round_cnt, num_out); end
    endtask

    task automatic test_reset_mid_round;
        enable = 1;
        get_number(6, 1);
        checks++; if (num_valid !== 1 || num_out !== 6) begin errors++; $display("FAIL pre_rst got %b %0d want 1 6", num_valid, num_out); end
        rst = 1; btn_prime = 1;
        tick;
        rst = 0; btn_prime = 0; enable = 0;
        checks++; if (num_valid !== 0 || result_ok !== 0 || result_miss !== 0 || rng_req !== 0 || prime_start !== 0) begin errors++; $display("FAIL rst_flags got %b%b%b%b%b want 00000", num_valid, result_ok, result_miss, rng_req, prime_start); end
        checks++; if (score !== 0 || round_cnt !== 0 || num_out !== 0) begin errors++; $display("FAIL rst_regs got %0d %0d %0d want 0 0 0", score, round_cnt, num_out); end
        tick;
        checks++; if (result_ok !== 0 || num_valid !== 0) begin errors++; $display("FAIL rst_after got %b%b want 00", result_ok, num_valid); end
    endtask

    initial begin
        rst = 1; enable = 0; score_clr = 0; rng_valid = 0; rng_value = 0;
        prime_done = 0; prime_is_prime = 0; btn_prime = 0; btn_notprime = 0;
        test_reset;
        test_basic;
        test_wrong;
        test_timeout;
        test_both_buttons;
        test_saturate;
        test_abort;
        test_reset_mid_round;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prime_round_sequencer.md
PRIME_ROUND_SEQUENCER -- requirements
Module: prime_round_sequencer

Interface
REQ-001 Parameter NUM_W, default 8, width of candidate number.
REQ-002 Parameter SCORE_W, default 8, width of score counter.
REQ-003 Parameter WINDOW_CYCLES, default 50000000, answer window length in clk cycles (>=2).
REQ-004 clk  in  1  single system clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 enable  in  1  game-running level from game controller; low = pause/stop.
REQ-007 score_clr  in  1  single-cycle pulse; clears score and round count.
REQ-008 rng_req  out  1  request for a new random number.
REQ-009 rng_valid  in  1  RNG handshake acknowledge; rng_value valid this cycle.
REQ-010 rng_value  in  NUM_W  random candidate number.
REQ-011 prime_start  out  1  single-cycle pulse starting primality checker.
REQ-012 prime_done  in  1  checker completion pulse; prime_is_prime valid this cycle.
REQ-013 prime_is_prime  in  1  checker verdict.
REQ-014 btn_prime, btn_notprime  in  1 each  debounced single-cycle player guess pulses.
REQ-015 num_out  out  NUM_W  number shown to player; num_valid  out  1  display-enable.
REQ-016 result_ok, result_miss  out  1 each  single-cycle round-outcome pulses.
REQ-017 score  out  SCORE_W  correct guesses; round_cnt  out  8  completed rounds.

Function
REQ-018 FSM states SHALL be IDLE, REQ, CHECK, PRESENT.
REQ-019 IDLE: enable=1 -> REQ next cycle; otherwise stay.
REQ-020 REQ: rng_req held high until rng_valid=1; that cycle rng_value latched into num_out (visible next cycle), rng_req drops, -> CHECK.
REQ-021 CHECK: prime_start pulses exactly one cycle on entry; wait for prime_done; latch prime_is_prime; -> PRESENT.
REQ-022 PRESENT: num_valid=1; window counter loads WINDOW_CYCLES-1 on entry, decrements each cycle.
REQ-023 Guess = exactly one of btn_prime/btn_notprime high; both high same cycle SHALL be ignored.
REQ-024 Correct guess at cycle t: result_ok=1 and score+1 at t+1; wrong guess: result_miss=1 at t+1, score unchanged.
REQ-025 Counter reaching 0 with no guess: result_miss pulse next cycle (timeout).
REQ-026 Round end (any outcome): round_cnt+1 (wraps 255->0), num_valid=0, -> REQ if enable=1 else IDLE.
REQ-027 Guess on the same cycle counter hits 0: guess wins, no timeout miss.
REQ-028 Score SHALL saturate at 2^SCORE_W-1.
REQ-029 Button pulses outside PRESENT SHALL be ignored.
REQ-030 enable=0 in REQ/CHECK/PRESENT: -> IDLE next cycle, rng_req=0, num_valid=0, no result pulse, score/round_cnt retained; a later prime_done is ignored.
REQ-031 score_clr clears score and round_cnt next cycle, takes priority over simultaneous increment; FSM state unaffected.

Reset
REQ-032 rst=1: state=IDLE; rng_req, prime_start, num_valid, result_ok, result_miss=0; num_out, score, round_cnt=0; window counter=0.
REQ-033 rst asserted mid-round SHALL abort the round with no result pulse; rst dominates every input.

Structure
REQ-034 Package prime_game_pkg SHALL hold the FSM state encoding, NUM_W/SCORE_W defaults and WINDOW_CYCLES default.
REQ-035 Window down-counter SHALL be sub-module round_window_timer (load, count, zero flag); all other logic in prime_round_sequencer.

Verification (WINDOW_CYCLES=8 for sim)
REQ-036 enable=1, rng_valid on 3rd REQ cycle with value 7, prime_done with is_prime=1, btn_prime in PRESENT -> num_out=7, result_ok one cycle, score 0->1, round_cnt 0->1.
REQ-037 value 9, is_prime=0, btn_prime -> result_miss one cycle, score unchanged.
REQ-038 No guess for 8 PRESENT cycles -> result_miss exactly once, new rng_req next round; guess on last window cycle -> result_ok, no miss.
REQ-039 btn_prime and btn_notprime same cycle, then btn_notprime for value 4 -> first ignored, then result_ok.
REQ-040 score preloaded to 255 via 255 correct rounds, one more correct -> score stays 255; score_clr coincident with correct guess -> score=0.
REQ-041 enable drops in CHECK, prime_done arrives later -> IDLE, no pulses; rst in PRESENT -> all outputs at reset values next cycle.
